// File: rtl/config_chain_loader.sv
// Streams a configuration image into the serial shift chain MSB-first while
// capturing the chain's previous contents into a readback word stream.
module config_chain_loader #(
   parameter int NBITS  = 5775,
   parameter int WORD_W = 32
) (
   input  logic              configClk,
   input  logic              configRst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] wrData,
   input  logic              wrValid,
   output logic              wrReady,
   output logic [WORD_W-1:0] rdData,
   output logic              rdValid,
   input  logic              rdReady,
   output logic              chainIn,
   output logic              chainShiftEn,
   input  logic              chainOut,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [1:0]        dbgState
);
   localparam int NWORDS = (NBITS + WORD_W - 1) / WORD_W;
   localparam int PAD    = NWORDS * WORD_W - NBITS;
   localparam int BCW    = $clog2(NBITS + 1);
   localparam int WCW    = $clog2(NWORDS + 1);
   localparam int XCW    = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DRAIN = 2'd2, DONE = 2'd3} stateT;

   // Handshakes: a word moves on wrValid && wrReady / rdValid && rdReady at the
   // clock edge; a producer holds valid and data stable until its ready is seen.
   stateT state, stateNext;

   logic [WORD_W-1:0] txReg, rxReg;
   logic [XCW-1:0]    txCnt, rxCnt;
   logic [BCW-1:0]    bitCnt;
   logic [WCW-1:0]    wordCnt;
   logic              abortNow, rxFull, shiftNow, wrTake, rdTake, rxMove;

   assign abortNow     = abort && (state == SHIFT || state == DRAIN);
   assign rxFull       = (rxCnt == XCW'(WORD_W));
   assign shiftNow     = (state == SHIFT) && !abortNow && (txCnt != '0) && !(rxFull && rdValid);
   assign wrReady      = (state == SHIFT) && !abortNow && (wordCnt < WCW'(NWORDS)) &&
                         ((txCnt == '0) || (txCnt == XCW'(1) && shiftNow));
   assign wrTake       = wrValid && wrReady;
   assign rdTake       = rdValid && rdReady;
   assign busy         = (state == SHIFT) || (state == DRAIN);
   // The captured word leaves rx when the holding register is free or being read now.
   assign rxMove       = busy && !abortNow && rxFull && (!rdValid || rdTake);
   assign chainShiftEn = shiftNow;
   assign chainIn      = shiftNow && txReg[WORD_W-1];
   assign done         = (state == DONE);
   assign dbgState     = state;

   always_ff @(posedge configClk or negedge configRst) begin
      if (!configRst) state <= IDLE;
      else            state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (start) stateNext = SHIFT;
         SHIFT:   if (abortNow) stateNext = IDLE;
                  else if (bitCnt == BCW'(NBITS)) stateNext = DRAIN;
         DRAIN:   if (abortNow) stateNext = IDLE;
                  else if (rxCnt == '0 && rdTake) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge configClk or negedge configRst) begin
      if (!configRst) begin
         txReg   <= '0;
         txCnt   <= '0;
         rxReg   <= '0;
         rxCnt   <= '0;
         bitCnt  <= '0;
         wordCnt <= '0;
         rdData  <= '0;
         rdValid <= 1'b0;
         aborted <= 1'b0;
      end else begin
         aborted <= abortNow;
         if (state == IDLE && start) begin
            // rx is pre-filled with PAD zero bits so the first readback word is right-aligned.
            txCnt   <= '0;
            rxReg   <= '0;
            rxCnt   <= XCW'(PAD);
            bitCnt  <= '0;
            wordCnt <= '0;
            rdValid <= 1'b0;
         end else if (abortNow) begin
            txCnt   <= '0;
            rxCnt   <= '0;
            rdValid <= 1'b0;
         end else begin
            if (wrTake) begin
               wordCnt <= wordCnt + WCW'(1);
               if (wordCnt == '0) begin
                  txReg <= wrData << PAD;
                  txCnt <= XCW'(WORD_W - PAD);
               end else begin
                  txReg <= wrData;
                  txCnt <= XCW'(WORD_W);
               end
            end else if (shiftNow) begin
               txReg <= txReg << 1;
               txCnt <= txCnt - XCW'(1);
            end

            if (shiftNow) begin
               bitCnt <= bitCnt + BCW'(1);
               rxReg  <= {rxReg[WORD_W-2:0], chainOut};
            end

            if (rxMove && shiftNow) rxCnt <= XCW'(1);
            else if (rxMove)        rxCnt <= '0;
            else if (shiftNow)      rxCnt <= rxCnt + XCW'(1);

            if (rxMove) begin
               rdData  <= rxReg;
               rdValid <= 1'b1;
            end else if (rdTake) begin
               rdValid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized bench for config_chain_loader: a behavioural chain plus image-level
// reference (expected chain image and readback words) checked on every load.
module tb_config_chain_loader;
   localparam int NB  = 70;
   localparam int W   = 32;
   localparam int NW  = 3;
   localparam int PAD = 26;

   logic          configClk = 1'b0;
   logic          configRst = 1'b0;
   logic          start = 1'b0, abort = 1'b0, wrValid = 1'b0, rdReady = 1'b0;
   logic [W-1:0]  wrData = '0;
   logic [W-1:0]  rdData;
   logic          wrReady, rdValid, chainIn, chainShiftEn, chainOut, busy, done, aborted;
   logic [1:0]    dbgState;

   logic [NB-1:0] chain, expChain;
   logic [W-1:0]  expQ[$];
   logic [W-1:0]  words[NW];
   int            testCnt = 0;
   int            failCnt = 0;

   config_chain_loader #(.NBITS(NB), .WORD_W(W)) dut (
      .configClk(configClk), .configRst(configRst), .start(start), .abort(abort),
      .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
      .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
      .chainIn(chainIn), .chainShiftEn(chainShiftEn), .chainOut(chainOut),
      .busy(busy), .done(done), .aborted(aborted), .dbgState(dbgState)
   );

   always #5 configClk = ~configClk;

   // Behavioural shift chain: MSB is the serial output, cleared by the same reset.
   always @(posedge configClk or negedge configRst) begin
      if (!configRst)        chain <= '0;
      else if (chainShiftEn) chain <= {chain[NB-2:0], chainIn};
   end
   assign chainOut = chain[NB-1];

   task automatic checkVal(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      testCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic randWords();
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
   endtask

   // mode 0: steady, 1: 5-cycle write gap, 2: readback stall, 3: abort at 40 shifts,
   // 4: random valid/ready with stray start pulses, 5: reset at 30 shifts
   task automatic runLoad(input int mode);
      logic [NB-1:0]   img;
      logic [NW*W-1:0] rdExp;
      logic [W-1:0]    prevRd, expWord;
      bit              prevHold, finished, gapped, eventSent;
      int              shifts, firstSh, lastSh, doneCnt, abCnt, wIdx, gapLeft;
      img = {words[0][W-PAD-1:0], words[1], words[2]};
      rdExp = {{PAD{1'b0}}, expChain};
      expQ.delete();
      for (int i = 0; i < NW; i++) expQ.push_back(rdExp[(NW-1-i)*W +: W]);
      prevRd = '0; prevHold = 0; finished = 0; gapped = 0; eventSent = 0;
      shifts = 0; firstSh = -1; lastSh = -1; doneCnt = 0; abCnt = 0; wIdx = 0; gapLeft = 0;

      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         start = (cyc == 0) || (mode == 4 && $urandom_range(0, 7) == 0);
         if (mode == 1 && !gapped && shifts == 37) begin
            gapped = 1;
            gapLeft = 5;
         end
         if (mode == 4) wrValid = ($urandom_range(0, 2) != 0);
         else           wrValid = (gapLeft == 0);
         if (gapLeft > 0) gapLeft--;
         wrData = (wIdx < NW) ? words[wIdx] : W'($urandom);
         if (mode == 2)      rdReady = (cyc >= 60);
         else if (mode == 4) rdReady = ($urandom_range(0, 2) != 0);
         else                rdReady = 1'b1;
         if (mode == 2 && cyc == 60) checkVal("stallShifts", shifts, 2 * W - PAD);
         abort = (mode == 3 && shifts == 40 && !eventSent);
         if (abort) eventSent = 1;

         if (mode == 5 && shifts == 30 && !eventSent) begin
            eventSent = 1;
            configRst = 1'b0;
            #1;
            checkVal("rstMidOut", {wrReady, rdValid, chainIn, chainShiftEn, busy, done, aborted}, 0);
            checkVal("rstMidRd", rdData, 0);
            checkVal("rstMidState", dbgState, 0);
            finished = 1;
         end else begin
            @(negedge configClk);
            if (prevHold) begin
               checkVal("rdHoldValid", rdValid, 1);
               checkVal("rdHoldData", rdData, prevRd);
            end
            prevHold = rdValid && !rdReady;
            prevRd = rdData;
            if (wrValid && wrReady) wIdx++;
            if (rdValid && rdReady) begin
               if (expQ.size() == 0) checkVal("rdExtra", 1, 0);
               else begin
                  expWord = expQ.pop_front();
                  checkVal("rdWord", rdData, expWord);
               end
            end
            if (chainShiftEn) begin
               if (shifts >= NB) checkVal("overShift", 1, 0);
               else checkVal("chainIn", chainIn, img[NB-1-shifts]);
               if (firstSh < 0) firstSh = cyc;
               lastSh = cyc;
               shifts++;
            end
            if (done) begin
               doneCnt++;
               if (mode != 3) finished = 1;
            end
            if (aborted) begin
               abCnt++;
               checkVal("abortIdle", {busy, wrReady, rdValid, done}, 0);
               finished = 1;
            end
            @(posedge configClk);
            #1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      if (!finished) checkVal("timeout", 0, 1);

      if (mode == 5) begin
         repeat (2) @(posedge configClk);
         #1 configRst = 1'b1;
         expChain = '0;
         @(posedge configClk);
         #1;
         checkVal("rstChain", chain, expChain);
         return;
      end

      @(negedge configClk);
      checkVal("pulseEnd", {done, aborted, busy}, 0);
      if (mode == 3) begin
         expChain = (expChain << 40) | (img >> (NB - 40));
         checkVal("abortShifts", shifts, 40);
         checkVal("abortPulses", abCnt, 1);
         checkVal("abortNoDone", doneCnt, 0);
      end else begin
         expChain = img;
         checkVal("shiftCount", shifts, NB);
         checkVal("donePulses", doneCnt, 1);
         checkVal("noAbort", abCnt, 0);
         checkVal("wordsTaken", wIdx, NW);
         checkVal("rdLeft", expQ.size(), 0);
         if (mode == 0) checkVal("spanSteady", lastSh - firstSh + 1, NB);
         if (mode == 1) checkVal("spanGap", lastSh - firstSh + 1, NB + 5);
      end
      checkVal("chainImage", chain, expChain);
      @(posedge configClk);
      #1;
   endtask

   initial begin
      configRst = 1'b0;
      repeat (3) @(posedge configClk);
      #1;
      checkVal("rstOut", {wrReady, rdValid, chainIn, chainShiftEn, busy, done, aborted}, 0);
      checkVal("rstRd", rdData, 0);
      checkVal("rstState", dbgState, 0);
      configRst = 1'b1;
      expChain = '0;
      @(posedge configClk);
      #1;
      checkVal("idleOut", {wrReady, rdValid, chainShiftEn, busy, done, aborted}, 0);
      checkVal("idleChain", chain, 0);

      words[0] = 32'hFFFFFFC0 | 32'h15;
      words[1] = 32'hA5A5A5A5;
      words[2] = 32'h0F0F0F0F;
      runLoad(0);
      for (int i = 0; i < NW; i++) words[i] = '0;
      runLoad(0);
      checkVal("zeroChain", chain, 0);

      randWords(); runLoad(1);
      randWords(); runLoad(2);
      randWords(); runLoad(3);
      randWords(); runLoad(0);
      for (int k = 0; k < 4; k++) begin
         randWords();
         runLoad(4);
      end
      randWords(); runLoad(5);
      randWords(); runLoad(0);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end
endmodule
